// File: rtl/quant_sar_pipe.sv
// Pipelined successive-approximation quantizer: index = floor(act * 2^IDX_W / max), clamped.
// Optional build macro QUANT_SAR_ROUND_EN switches the output stage to round-to-nearest.
module quant_sar_pipe #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_max,
  input  logic [DATA_W-1:0] i_activation,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [IDX_W-1:0]  o_index,
  output logic              o_sat,
  output logic [TAG_W-1:0]  o_tag
);

  // Stage 0 is the pre stage; stages 1..IDX_W each resolve one quotient bit, MSB first.
  localparam int NS = IDX_W + 1;

  // Handshake: a transfer occurs on a rising clk edge where valid && ready. The whole pipe
  // moves as one (adv) whenever the output register is empty or being drained, so o_ready
  // never depends on i_valid; when adv is low every stage, valid bits included, holds.
  logic adv;
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  logic [NS-1:0]     vld;
  logic [NS-1:0]     sat;
  logic [DATA_W-1:0] rem [NS];
  logic [DATA_W-1:0] mx  [NS];
  logic [IDX_W-1:0]  qt  [NS];
  logic [TAG_W-1:0]  tg  [NS];
  logic [DATA_W:0]   rsh [NS];
  logic [NS-1:0]     ge;

  // Shifted remainder needs DATA_W+1 bits; the stored remainder stays below max.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      rsh[s] = '0;
      ge[s]  = 1'b0;
    end
    for (int s = 1; s < NS; s++) begin
      rsh[s] = {rem[s-1], 1'b0};
      ge[s]  = rsh[s] >= {1'b0, mx[s-1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld <= '0;
    else if (adv) vld <= {vld[NS-2:0], i_valid};
  end

  // Data registers of bubble stages are don't-care, so they load unconditionally on adv.
  always_ff @(posedge clk) begin
    if (adv) begin
      mx[0]  <= i_max;
      tg[0]  <= i_tag;
      rem[0] <= i_activation;
      if (i_max == '0) begin
        sat[0] <= 1'b1;
        qt[0]  <= '0;
      end else if (i_activation >= i_max) begin
        sat[0] <= 1'b1;
        qt[0]  <= '1;
      end else begin
        sat[0] <= 1'b0;
        qt[0]  <= '0;
      end
      for (int s = 1; s < NS; s++) begin
        mx[s]  <= mx[s-1];
        tg[s]  <= tg[s-1];
        sat[s] <= sat[s-1];
        if (!sat[s-1] && ge[s]) begin
          rem[s] <= DATA_W'(rsh[s] - {1'b0, mx[s-1]});
          qt[s]  <= qt[s-1] | (IDX_W'(1) << (IDX_W - s));
        end else if (!sat[s-1]) begin
          rem[s] <= rsh[s][DATA_W-1:0];
          qt[s]  <= qt[s-1];
        end else begin
          rem[s] <= rem[s-1];
          qt[s]  <= qt[s-1];
        end
      end
    end
  end

  logic [IDX_W-1:0] fin_idx;
  logic             fin_sat;

  always_comb begin
    fin_idx = qt[NS-1];
    fin_sat = sat[NS-1];
`ifdef QUANT_SAR_ROUND_EN
    // Round up when the leftover fraction is at least one half of an index step.
    if (!sat[NS-1] && ({rem[NS-1], 1'b0} >= {1'b0, mx[NS-1]})) begin
      if (&qt[NS-1]) fin_sat = 1'b1;
      else           fin_idx = qt[NS-1] + IDX_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_index <= '0;
      o_sat   <= 1'b0;
      o_tag   <= '0;
    end else if (adv) begin
      o_valid <= vld[NS-1];
      if (vld[NS-1]) begin
        o_index <= fin_idx;
        o_sat   <= fin_sat;
        o_tag   <= tg[NS-1];
      end
    end
  end

endmodule

// File: tb/tb_quant_sar_pipe.sv
// Randomised and directed bench for quant_sar_pipe against an arithmetic reference model.
module tb_quant_sar_pipe;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 8;
  localparam int TAG_W  = 4;
  localparam int LAT    = IDX_W + 2;
  localparam int W      = TAG_W + 1 + IDX_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_max;
  logic [DATA_W-1:0] i_activation;
  logic [TAG_W-1:0]  i_tag;
  logic              o_valid;
  logic              i_ready;
  logic [IDX_W-1:0]  o_index;
  logic              o_sat;
  logic [TAG_W-1:0]  o_tag;

  quant_sar_pipe #(.DATA_W(DATA_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_max(i_max), .i_activation(i_activation), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_index(o_index), .o_sat(o_sat), .o_tag(o_tag)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---- checking ----
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: exact integer division in 64-bit arithmetic, result packed as {tag, sat, idx}.
  function automatic logic [W-1:0] model(input logic [31:0] mx, input logic [31:0] act,
                                         input logic [TAG_W-1:0] tag);
    logic [63:0] num, q, r;
    logic        s;
    if (mx == 0) return {tag, 1'b1, {IDX_W{1'b0}}};
    if (act >= mx) return {tag, 1'b1, {IDX_W{1'b1}}};
    num = {32'b0, act} << IDX_W;
    q   = num / {32'b0, mx};
    r   = num % {32'b0, mx};
    s   = 1'b0;
`ifdef QUANT_SAR_ROUND_EN
    if (2 * r >= {32'b0, mx}) q = q + 1;
    if (q == (64'd1 << IDX_W)) begin
      q = (64'd1 << IDX_W) - 1;
      s = 1'b1;
    end
`endif
    return {tag, s, q[IDX_W-1:0]};
  endfunction

  // ---- scoreboard ----
  logic [W-1:0] exp_q[$];
  int acc_cnt = 0, out_cnt = 0;
  int pop_n = 0, pop_first = 0, pop_last = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      check("o_ready", o_ready, !o_valid || i_ready);
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          check("index", o_index, exp_q[0][IDX_W-1:0]);
          check("sat", o_sat, exp_q[0][IDX_W]);
          check("tag", o_tag, exp_q[0][W-1:IDX_W+1]);
          if (i_ready) begin
            void'(exp_q.pop_front());
            out_cnt++;
            if (pop_n == 0) pop_first = cyc;
            pop_last = cyc;
            pop_n++;
          end
        end
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_max, i_activation, i_tag));
        acc_cnt++;
      end
    end
  end

  // ---- driver tasks ----
  task automatic send(input logic [31:0] mx, input logic [31:0] act, input logic [TAG_W-1:0] tag);
    logic took;
    int   guard;
    i_valid = 1'b1; i_max = mx; i_activation = act; i_tag = tag;
    took = 1'b0; guard = 0;
    while (!took && guard < 1000) begin
      @(negedge clk); took = o_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!took) check("send_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  // Sends one sample into an idle pipe and checks the cycle count to its result,
  // counting the acceptance cycle as cycle 1.
  task automatic timed(input logic [31:0] mx, input logic [31:0] act, input logic [TAG_W-1:0] tag);
    int n;
    send(mx, act, tag);
    n = 1;
    while (!o_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, LAT);
    @(posedge clk); #1;
  endtask

  task automatic rand_sample(output logic [31:0] mx, output logic [31:0] act);
    case ($urandom_range(0, 9))
      0:       mx = 0;
      1, 2:    mx = $urandom_range(1, 300);
      default: mx = $urandom;
    endcase
    if ($urandom_range(0, 4) == 0 || mx == 0) act = $urandom;
    else act = $urandom % mx;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // ---- stimulus ----
  initial begin
    logic [31:0] mx, act;
    logic        acc;
    int          vcnt;
    reset_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_max = '0; i_activation = '0; i_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_index", o_index, 0);
    check("rst_o_sat", o_sat, 0);
    check("rst_o_tag", o_tag, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_o_ready", o_ready, 1);

    // directed points, including the saturation and rounding boundaries
    timed(1000, 500, 3);
    timed(1000, 1000, 4);
    timed(1000, 32'hFFFF_FFFF, 5);
    timed(0, 7, 6);
    timed(1000, 3, 7);
    timed(1000, 999, 8);
    timed(1, 0, 9);
    drain("directed_drain");

    // 64 back-to-back samples with the sink always ready
    pop_n = 0;
    for (int k = 0; k < 64; k++) begin
      rand_sample(mx, act);
      i_valid = 1'b1; i_max = mx; i_activation = act; i_tag = TAG_W'(k);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    drain("b2b_drain");
    check("b2b_count", pop_n, 64);
    check("b2b_consecutive", pop_last - pop_first, 63);

    // continuous input, randomly stalling sink
    acc_cnt = 0; out_cnt = 0;
    rand_sample(mx, act);
    i_valid = 1'b1; i_max = mx; i_activation = act; i_tag = TAG_W'($urandom);
    repeat (300) begin
      @(negedge clk); acc = o_ready;
      @(posedge clk); #1;
      i_ready = 1'($urandom_range(0, 1));
      if (acc) begin
        rand_sample(mx, act);
        i_max = mx; i_activation = act; i_tag = TAG_W'($urandom);
      end
    end
    i_valid = 1'b0; i_ready = 1'b1;
    drain("stall_drain");
    check("stall_no_loss", out_cnt, acc_cnt);

    // reset with five samples in flight
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_max = 1000; i_activation = 32'(100 * k); i_tag = TAG_W'(k + 1);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o_index", o_index, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    vcnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (o_valid) vcnt++;
    end
    check("no_stale_results", vcnt, 0);
    timed(1000, 250, 10);
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
